// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX->MEM bundle and extracts load data from the data SRAM.
// A small hold buffer keeps the load data stable while this stage is frozen by a stall.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_ID_WD = 38,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_BU   = 3'b010,
    LD_H    = 3'b011,
    LD_HU   = 3'b100,
    LD_W    = 3'b101
  } load_op_e;

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic [31:0]             hold_buf;
  logic                    hold_valid;

  logic [31:0] mem_pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic [2:0]  load_op;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;

  assign mem_pc       = bus_r[78:47];
  assign data_ram_en  = bus_r[46];
  assign data_ram_wen = bus_r[45:42];
  assign load_op      = bus_r[41:39];
  assign sel_rf_res   = bus_r[38];
  assign rf_we        = bus_r[37];
  assign rf_waddr     = bus_r[36:32];
  assign ex_result    = bus_r[31:0];

  logic stop_mem;
  logic stop_wb;
  logic take_bubble;
  logic take_new;
  logic load_valid;
  logic is_load;

  assign stop_mem    = stall[3];
  assign stop_wb     = stall[4];
  assign take_bubble = stop_mem & ~stop_wb;
  assign take_new    = ~stop_mem;
  assign load_valid  = (load_op != LD_NONE) && (load_op <= LD_W);
  assign is_load     = load_valid & data_ram_en;

  // Stall bits belonging to other stages are not used here.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall[2:0], stall[StallBus-1:5]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r      <= '0;
      hold_buf   <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (take_bubble) begin
        bus_r <= '0;
      end else if (take_new) begin
        bus_r <= ex_to_mem_bus;
      end

      // SRAM data is only valid one cycle; latch it the first frozen cycle so it survives the stall.
      if (take_bubble || take_new) begin
        hold_valid <= 1'b0;
      end else if (is_load && !hold_valid) begin
        hold_buf   <= data_sram_rdata;
        hold_valid <= 1'b1;
      end
    end
  end

  logic [31:0] rdata_src;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        use_load;

  assign rdata_src = hold_valid ? hold_buf : data_sram_rdata;
  assign half_sel  = ex_result[1] ? rdata_src[31:16] : rdata_src[15:0];

  always_comb begin
    byte_sel = rdata_src[7:0];
    case (ex_result[1:0])
      2'd0:    byte_sel = rdata_src[7:0];
      2'd1:    byte_sel = rdata_src[15:8];
      2'd2:    byte_sel = rdata_src[23:16];
      default: byte_sel = rdata_src[31:24];
    endcase
  end

  always_comb begin
    load_data = ex_result;
    case (load_op_e'(load_op))
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_data = {24'd0, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_data = {16'd0, half_sel};
      LD_W:    load_data = rdata_src;
      default: load_data = ex_result;
    endcase
  end

  // Stores never write back memory data even if load_op is set.
  assign use_load = sel_rf_res & load_valid & (data_ram_wen == 4'd0);

  logic [31:0] rf_wdata;
  assign rf_wdata = use_load ? load_data : ex_result;

  assign mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, stall/reset sequences and a randomized run.
// Expected values come from constants or from a word-level model of the load rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [78:0] ex_to_mem_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;

  int n_tests = 0;
  int n_fail  = 0;

  logic [78:0] m_bus  = '0;
  logic        m_hv   = 1'b0;
  logic [31:0] m_hold = '0;

  mem_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .ex_to_mem_bus(ex_to_mem_bus),
    .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus(mem_to_wb_bus),
    .mem_to_id_bus(mem_to_id_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [78:0] mk(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                     input logic [2:0] op, input logic sel, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] res);
    return {pc, en, wen, op, sel, we, waddr, res};
  endfunction

  function automatic logic [69:0] wb(input logic [31:0] pc, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] wdata);
    return {pc, we, waddr, wdata};
  endfunction

  // Reference: arithmetic view of the load rules (shift to the lane, mask, sign-adjust).
  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] res,
                                            input logic [31:0] rdata, input logic sel,
                                            input logic [3:0] wen);
    longint v;
    longint word;
    int a;
    word = longint'(rdata);
    a = int'(res % 4);
    if (!sel || wen != 0 || op == 0 || op > 5) return res;
    case (op)
      3'd1: begin v = (word >> (8 * a)) % 256; if (v >= 128) v = v - 256; end
      3'd2: v = (word >> (8 * a)) % 256;
      3'd3: begin v = (word >> (16 * (a / 2))) % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = (word >> (16 * (a / 2))) % 65536;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  task automatic check_bus(input string name, input logic [69:0] exp);
    n_tests++;
    if (mem_to_wb_bus !== exp) begin
      n_fail++;
      $display("FAIL %s wb: got %h expected %h", name, mem_to_wb_bus, exp);
    end
    n_tests++;
    if (mem_to_id_bus !== exp[37:0]) begin
      n_fail++;
      $display("FAIL %s id: got %h expected %h", name, mem_to_id_bus, exp[37:0]);
    end
  endtask

  // One clock: drive stall/EX bundle, advance model at the edge, then present the SRAM data.
  task automatic step(input logic [5:0] st, input logic [78:0] ex, input logic [31:0] rd_next);
    stall = st;
    ex_to_mem_bus = ex;
    @(posedge clk);
    if (st[3] && !st[4]) begin
      m_bus = '0;
      m_hv  = 1'b0;
    end else if (!st[3]) begin
      m_bus = ex;
      m_hv  = 1'b0;
    end else if (!m_hv && m_bus[46] && m_bus[41:39] >= 3'd1 && m_bus[41:39] <= 3'd5) begin
      m_hold = data_sram_rdata;
      m_hv   = 1'b1;
    end
    #1 data_sram_rdata = rd_next;
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        sel;
    logic [3:0]  wen;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [5:0] ST_RUN    = 6'b000000;
  localparam logic [5:0] ST_FREEZE = 6'b011000;
  localparam logic [5:0] ST_BUBBLE = 6'b001000;

  initial begin
    logic [31:0] exp_wd;
    logic [31:0] src;

    tbl.push_back('{3'b001, 32'h0000_1003, 32'h80FF_1234, 1'b1, 4'h0, 32'hFFFF_FF80});
    tbl.push_back('{3'b010, 32'h0000_1003, 32'h80FF_1234, 1'b1, 4'h0, 32'h0000_0080});
    tbl.push_back('{3'b001, 32'h0000_0000, 32'h80FF_1234, 1'b1, 4'h0, 32'h0000_0034});
    tbl.push_back('{3'b001, 32'h0000_0001, 32'h80FF_1234, 1'b1, 4'h0, 32'h0000_0012});
    tbl.push_back('{3'b001, 32'h0000_0002, 32'h80FF_1234, 1'b1, 4'h0, 32'hFFFF_FFFF});
    tbl.push_back('{3'b010, 32'h0000_0002, 32'h80FF_1234, 1'b1, 4'h0, 32'h0000_00FF});
    tbl.push_back('{3'b100, 32'h0000_0002, 32'hBEEF_0001, 1'b1, 4'h0, 32'h0000_BEEF});
    tbl.push_back('{3'b011, 32'h0000_0002, 32'hBEEF_0001, 1'b1, 4'h0, 32'hFFFF_BEEF});
    tbl.push_back('{3'b011, 32'h0000_0003, 32'hBEEF_0001, 1'b1, 4'h0, 32'hFFFF_BEEF});
    tbl.push_back('{3'b011, 32'h0000_0001, 32'hBEEF_8001, 1'b1, 4'h0, 32'hFFFF_8001});
    tbl.push_back('{3'b100, 32'h0000_0000, 32'hBEEF_8001, 1'b1, 4'h0, 32'h0000_8001});
    tbl.push_back('{3'b101, 32'h0000_0003, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'hDEAD_BEEF});
    tbl.push_back('{3'b000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'h1234_5678});
    tbl.push_back('{3'b110, 32'h0000_0042, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'h0000_0042});
    tbl.push_back('{3'b111, 32'h0000_0043, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'h0000_0043});
    tbl.push_back('{3'b101, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0000_0044});
    tbl.push_back('{3'b101, 32'h0000_0048, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'h0000_0048});

    // Reset: outputs zero while asserted and right after release, even with a load presented.
    ex_to_mem_bus   = mk(32'h0000_0ABC, 1'b1, 4'h0, 3'b101, 1'b1, 1'b1, 5'd3, 32'h0);
    data_sram_rdata = 32'hFFFF_FFFF;
    #1 check_bus("reset_active", '0);
    #11 rst = 1'b0;
    #1 check_bus("reset_release", '0);

    foreach (tbl[i]) begin
      step(ST_RUN, mk(32'h100 + 32'(i * 4), 1'b1, tbl[i].wen, tbl[i].op, tbl[i].sel, 1'b1,
                      5'(i + 1), tbl[i].addr), tbl[i].rdata);
      check_bus($sformatf("table_%0d", i), wb(32'h100 + 32'(i * 4), 1'b1, 5'(i + 1), tbl[i].exp));
    end

    // Frozen lw must keep the first-cycle SRAM word through the stall and at release.
    step(ST_RUN, mk(32'h200, 1'b1, 4'h0, 3'b101, 1'b1, 1'b1, 5'd7, 32'h40), 32'h1111_1111);
    check_bus("lw_issue", wb(32'h200, 1'b1, 5'd7, 32'h1111_1111));
    for (int k = 0; k < 3; k++) begin
      step(ST_FREEZE, mk(32'h204, 1'b0, 4'h0, 3'b000, 1'b0, 1'b1, 5'd8, 32'h5), 32'hDEAD_0000);
      check_bus($sformatf("lw_stall_%0d", k), wb(32'h200, 1'b1, 5'd7, 32'h1111_1111));
    end
    stall = ST_RUN;
    #1 check_bus("lw_release", wb(32'h200, 1'b1, 5'd7, 32'h1111_1111));

    // ALU result passes through; MEM stop with WB running inserts a bubble.
    step(ST_RUN, mk(32'h300, 1'b0, 4'h0, 3'b000, 1'b0, 1'b1, 5'd4, 32'h1234_5678), 32'hAAAA_AAAA);
    check_bus("alu", wb(32'h300, 1'b1, 5'd4, 32'h1234_5678));
    step(ST_BUBBLE, mk(32'h304, 1'b0, 4'h0, 3'b000, 1'b0, 1'b1, 5'd6, 32'h9), 32'hAAAA_AAAA);
    check_bus("bubble", '0);

    // Async reset between edges while a load is held.
    step(ST_RUN, mk(32'h400, 1'b1, 4'h0, 3'b101, 1'b1, 1'b1, 5'd9, 32'h0), 32'hAAAA_5555);
    step(ST_FREEZE, mk(32'h404, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0), 32'h0BAD_0BAD);
    check_bus("held_before_rst", wb(32'h400, 1'b1, 5'd9, 32'hAAAA_5555));
    #2 rst = 1'b1;
    #1 check_bus("async_rst", '0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_bus("after_rst", '0);
    step(ST_RUN, mk(32'h408, 1'b1, 4'h0, 3'b101, 1'b1, 1'b1, 5'd10, 32'h0), 32'hCAFE_BABE);
    check_bus("post_rst_load", wb(32'h408, 1'b1, 5'd10, 32'hCAFE_BABE));
    step(ST_FREEZE, mk(32'h40C, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0), 32'h1212_1212);
    check_bus("post_rst_hold", wb(32'h408, 1'b1, 5'd10, 32'hCAFE_BABE));

    // Randomized run against the model; first cycle runs so the model is in sync.
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  st;
      logic [78:0] ex;
      int r;
      r  = (n == 0) ? 0 : int'($urandom_range(0, 9));
      st = 6'($urandom) & 6'b100111;
      case (r)
        5, 6:    st = st | ST_FREEZE;
        7:       st = st | ST_BUBBLE;
        8:       st = st | 6'b010000;
        9:       st = 6'b111111;
        default: st = st;
      endcase
      ex = mk($urandom, 1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
              3'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
              5'($urandom), $urandom);
      step(st, ex, $urandom);
      src    = m_hv ? m_hold : data_sram_rdata;
      exp_wd = ref_wdata(m_bus[41:39], m_bus[31:0], src, m_bus[38], m_bus[45:42]);
      check_bus($sformatf("rand_%0d", n), wb(m_bus[78:47], m_bus[37], m_bus[36:32], exp_wd));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
